cisc_control_unit: RTL
======================

// Module: cisc_control_unit
// PURPOSE
//  Microsequencer for the 16-bit CISC datapath: register bank, ALSU, status register, DR, AR, PC and IR.
//  Runs fetch/decode/execute. Drives every datapath load/select/output-enable and the bank read/write addresses.
//  Runs the memory req/ack handshake on the shared Datos/Direcciones buses.
//  Ends in a sticky HALT on halt opcode, illegal opcode or memory timeout.
// PARAMETERS
//  PASS_A_FUN   3'b000  ALSU Fun code giving ALSUout = A
//  PASS_B_FUN   3'b001  ALSU Fun code giving ALSUout = B
//  MEM_TIMEOUT  16      max cycles in a memory wait state without mem_ack (>=2)
// PORTS
//  clk           in   1  clock, rising edge
//  reset         in   1  synchronous, active-high
//  ir            in  16  IR contents: [15:12] op, [11:9] rd/cond, [8:6] ra, [5:3] rb, [2:0] fun
//  cond_flag     in   1  XOR(status mux, neg_s) output
//  mem_ack       in   1  memory completes current access this cycle
//  mem_req/mem_we out 1  access request / 1=write
//  load_ir,load_pc,load_ar,load_dr,load_s  out 1  register load enables
//  select_pc     out  2  0 Datos, 1 ALSUout, 2 Cero, 3 PC+1
//  select_ar,select_dr  out 1  0 Datos, 1 ALSUout
//  wire_select   out  1  bank write data: 0 ALSUout, 1 Datos
//  write_enable  out  1  bank write; write_address out 3 (=ir[11:9])
//  read_address_a/b  out 3  =ir[8:6] / ir[5:3]
//  fun           out  3  ALSU function
//  select_s      out  2  status mux select (=ir[10:9]); neg_s out 1 (=ir[11])
//  oe_pc_a,oe_pc_d,oe_ar,oe_dr  out 1  bus tri-state enables
//  halted,bus_error,illegal_op  out 1  registered sticky flags
// BEHAVIOUR
//  - State register only. Control outputs are combinational from state, ir and mem_ack.
//  - Every output not listed for a state is 0. fun defaults to ir[2:0].
//  - Reset: synchronous. reset=1 at an edge forces S_RESET and clears all flags.
//    Reset wins over every event, including mid-access; mem_req drops the next cycle.
//  - S_RESET: select_pc=2, load_pc=1 -> S_FETCH.
//  - S_FETCH: oe_pc_a, mem_req. On ack: load_ir, select_pc=3, load_pc -> S_DECODE.
//  - S_DECODE: 1 cycle, dispatch on ir[15:12]:
//    0 NOP -> FETCH; 1 ALU -> S_ALU; 2 LD -> S_LD_AR; 3 ST -> S_ST_AR; 4 JMP / 5 BR / 6 LDI -> S_IMM.
//    F HALT -> S_HALT with halted=1. Other ops -> S_HALT with illegal_op=1, halted=1.
//  - S_ALU: write_enable, wire_select=0, load_s -> FETCH. Result rd = ra fun rb.
//  - S_LD_AR: fun=PASS_A, select_ar=1, load_ar -> S_LD_MEM.
//  - S_LD_MEM: oe_ar, mem_req. On ack: write_enable, wire_select=1 -> FETCH.
//  - S_ST_AR (as S_LD_AR) -> S_ST_DR: fun=PASS_B, select_dr=1, load_dr -> S_ST_MEM.
//  - S_ST_MEM: oe_ar, oe_dr, mem_req, mem_we. On ack -> FETCH.
//  - S_IMM: oe_pc_a, mem_req. On ack, by opcode:
//    JMP: select_pc=0, load_pc. BR: select_pc = cond_flag ? 0 : 3, load_pc.
//    LDI: write_enable, wire_select=1, select_pc=3, load_pc.
//    Then -> FETCH.
//  - Timeout counter: cleared on entry to any wait state (FETCH, LD_MEM, ST_MEM, IMM).
//    Increments each cycle without ack. At MEM_TIMEOUT cycles with no ack:
//    bus_error=1, halted=1, -> S_HALT, no load strobes that cycle.
//  - Ack in the same cycle the count reaches MEM_TIMEOUT: the ack wins.
//  - S_HALT: all strobes/enables 0; held until reset. oe_pc_d is never driven (reserved).
//  - mem_ack outside a wait state is ignored.
//  - Latency with zero-wait memory: ALU 3 cycles, LD 4, ST 5, JMP/BR/LDI 3.
// TESTING
//  - Reset then instant-ack memory: cycle after reset drops, load_pc=1 with select_pc=2.
//    Next cycle mem_req=1 and oe_pc_a=1.
//  - Fetch ir=16'h1298 (ALU rd=1 ra=2 rb=3 fun=0), ack after 2 wait cycles.
//    load_ir on the ack cycle, DECODE, then S_ALU with write_enable=1, write_address=1, read a=2 b=3, load_s=1.
//  - ST ir=16'h3088 (ra=2 rb=1): fun=000 with load_ar.
//    Next cycle fun=001 with load_dr. Then mem_we=1, oe_ar=1, oe_dr=1 until ack.
//  - BR: cond_flag=1 at ack -> select_pc=0. Repeat with cond_flag=0 -> select_pc=3.
//  - Never ack in FETCH: exactly MEM_TIMEOUT cycles of mem_req, then bus_error=1, halted=1, all strobes 0.
//  - Illegal op 16'h7000 -> illegal_op=1 and halted. reset during S_LD_MEM -> S_RESET next edge, flags 0.

Source files
------------

// File: rtl/cisc_control_unit.sv
// -----------------------------------------------------------------------------
// cisc_control_unit
//
// Microsequencer for the 16-bit CISC datapath (register bank, ALSU, status
// register, DR, AR, PC, IR). Runs fetch / decode / execute, drives every
// datapath load, select and bus output-enable, and runs the req/ack handshake
// with memory on the shared Datos/Direcciones buses. Ends in a sticky HALT on
// the halt opcode, an illegal opcode or a memory timeout.
//
// Only the state, the wait counter and the three flags are registered. All
// control outputs are combinational from state, ir, cond_flag and mem_ack.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   ir[15:0]                      IR: [15:12] op, [11:9] rd/cond, [8:6] ra,
//                                 [5:3] rb, [2:0] fun
//   cond_flag                     selected status bit XOR neg_s
//   mem_ack                       memory completes the current access this cycle
//   mem_req, mem_we               access request, 1 = write
//   load_ir/pc/ar/dr/s            register load enables
//   select_pc[1:0]                0 Datos, 1 ALSUout, 2 zero, 3 PC+1
//   select_ar, select_dr          0 Datos, 1 ALSUout
//   wire_select                   bank write data: 0 ALSUout, 1 Datos
//   write_enable, write_address   bank write port (address = ir[11:9])
//   read_address_a/b              bank read ports (ir[8:6] / ir[5:3])
//   fun[2:0]                      ALSU function (ir[2:0] unless overridden)
//   select_s[1:0], neg_s          status mux select (ir[10:9]) and invert (ir[11])
//   oe_pc_a, oe_pc_d, oe_ar, oe_dr  bus tri-state enables (oe_pc_d reserved, 0)
//   halted, bus_error, illegal_op registered sticky flags
// -----------------------------------------------------------------------------
module cisc_control_unit #(
  parameter logic [2:0] PASS_A_FUN  = 3'b000,
  parameter logic [2:0] PASS_B_FUN  = 3'b001,
  parameter int         MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        cond_flag,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        load_ir,
  output logic        load_pc,
  output logic        load_ar,
  output logic        load_dr,
  output logic        load_s,
  output logic [1:0]  select_pc,
  output logic        select_ar,
  output logic        select_dr,
  output logic        wire_select,
  output logic        write_enable,
  output logic [2:0]  write_address,
  output logic [2:0]  read_address_a,
  output logic [2:0]  read_address_b,
  output logic [2:0]  fun,
  output logic [1:0]  select_s,
  output logic        neg_s,
  output logic        oe_pc_a,
  output logic        oe_pc_d,
  output logic        oe_ar,
  output logic        oe_dr,
  output logic        halted,
  output logic        bus_error,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_ALU,
    S_LD_AR,
    S_LD_MEM,
    S_ST_AR,
    S_ST_DR,
    S_ST_MEM,
    S_IMM,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_BR   = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] PC_DATOS = 2'd0;
  localparam logic [1:0] PC_ZERO  = 2'd2;
  localparam logic [1:0] PC_INC   = 2'd3;

  // Counter holds 0..MEM_TIMEOUT-1: the number of completed ack-less cycles
  // in the current wait state.
  localparam int          CW       = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt;
  logic            in_wait;
  logic            timeout;
  logic            set_halted, set_bus_error, set_illegal;
  logic [3:0]      op;

  assign op             = ir[15:12];
  assign write_address  = ir[11:9];
  assign read_address_a = ir[8:6];
  assign read_address_b = ir[5:3];
  assign select_s       = ir[10:9];
  assign neg_s          = ir[11];

  assign in_wait = (state == S_FETCH) || (state == S_LD_MEM) ||
                   (state == S_ST_MEM) || (state == S_IMM);
  // The MEM_TIMEOUT-th ack-less cycle expires; an ack in that same cycle wins.
  assign timeout = in_wait && !mem_ack && (wait_cnt == CNT_LAST);

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_next    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    load_ir       = 1'b0;
    load_pc       = 1'b0;
    load_ar       = 1'b0;
    load_dr       = 1'b0;
    load_s        = 1'b0;
    select_pc     = PC_DATOS;
    select_ar     = 1'b0;
    select_dr     = 1'b0;
    wire_select   = 1'b0;
    write_enable  = 1'b0;
    fun           = ir[2:0];
    oe_pc_a       = 1'b0;
    oe_pc_d       = 1'b0;
    oe_ar         = 1'b0;
    oe_dr         = 1'b0;
    set_halted    = 1'b0;
    set_bus_error = 1'b0;
    set_illegal   = 1'b0;

    unique case (state)
      S_RESET: begin
        select_pc  = PC_ZERO;
        load_pc    = 1'b1;
        state_next = S_FETCH;
      end

      S_FETCH: begin
        oe_pc_a = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          load_ir    = 1'b1;
          select_pc  = PC_INC;
          load_pc    = 1'b1;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        unique case (op)
          OP_NOP:                 state_next = S_FETCH;
          OP_ALU:                 state_next = S_ALU;
          OP_LD:                  state_next = S_LD_AR;
          OP_ST:                  state_next = S_ST_AR;
          OP_JMP, OP_BR, OP_LDI:  state_next = S_IMM;
          OP_HALT: begin
            set_halted = 1'b1;
            state_next = S_HALT;
          end
          default: begin
            set_illegal = 1'b1;
            set_halted  = 1'b1;
            state_next  = S_HALT;
          end
        endcase
      end

      S_ALU: begin
        write_enable = 1'b1;
        load_s       = 1'b1;
        state_next   = S_FETCH;
      end

      S_LD_AR, S_ST_AR: begin
        // Effective address is the ra register passed straight through the ALSU.
        fun        = PASS_A_FUN;
        select_ar  = 1'b1;
        load_ar    = 1'b1;
        state_next = (state == S_LD_AR) ? S_LD_MEM : S_ST_DR;
      end

      S_LD_MEM: begin
        oe_ar   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          write_enable = 1'b1;
          wire_select  = 1'b1;
          state_next   = S_FETCH;
        end
      end

      S_ST_DR: begin
        fun        = PASS_B_FUN;
        select_dr  = 1'b1;
        load_dr    = 1'b1;
        state_next = S_ST_MEM;
      end

      S_ST_MEM: begin
        oe_ar   = 1'b1;
        oe_dr   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_next = S_FETCH;
      end

      S_IMM: begin
        // The immediate word sits at PC; the opcode decides where it goes.
        oe_pc_a = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          load_pc    = 1'b1;
          state_next = S_FETCH;
          if (op == OP_JMP) begin
            select_pc = PC_DATOS;
          end else if (op == OP_BR) begin
            select_pc = cond_flag ? PC_DATOS : PC_INC;
          end else begin
            write_enable = 1'b1;
            wire_select  = 1'b1;
            select_pc    = PC_INC;
          end
        end
      end

      S_HALT: state_next = S_HALT;

      default: begin
        set_halted = 1'b1;
        state_next = S_HALT;
      end
    endcase

    // Expired wait: no load strobes this cycle (none fire without ack anyway).
    if (timeout) begin
      set_bus_error = 1'b1;
      set_halted    = 1'b1;
      state_next    = S_HALT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_RESET;
      wait_cnt   <= '0;
      halted     <= 1'b0;
      bus_error  <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state) wait_cnt <= '0;
      else if (in_wait)        wait_cnt <= wait_cnt + 1'b1;
      halted     <= halted     | set_halted;
      bus_error  <= bus_error  | set_bus_error;
      illegal_op <= illegal_op | set_illegal;
    end
  end

endmodule
